// File: rtl/seq_pkg.sv
// Shared definitions for the sequence frame generator, the recognizer and their benches.
package seq_pkg;

  // Frame generator FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Saturation point of the "ones seen" counter: two 1s are all the recognizer needs
  localparam logic [1:0] ONES_SAT = 2'd2;

endpackage

// File: rtl/seq_ref_model.sv
// Reference model of the "at least two 1s and an odd number of 0s" recognizer.
// Tracks a saturating ones counter and the zero-count parity; expect_f is the
// registered Moore output, expect_nxt is the value it takes at the next edge.
module seq_ref_model (
  input  logic clk,
  input  logic rst,        // asynchronous, active-low
  input  logic clr,        // synchronous clear of the model state
  input  logic en,         // a valid bit is present on bit_in this cycle
  input  logic bit_in,
  output logic expect_f,
  output logic expect_nxt
);
  import seq_pkg::*;

  logic [1:0] ones_q, ones_d;
  logic       zpar_q, zpar_d;
  logic       f_q;

  // Next-state of the model: clear wins, otherwise consume one bit when enabled
  always_comb begin
    ones_d = ones_q;
    zpar_d = zpar_q;
    if (clr) begin
      ones_d = 2'd0;
      zpar_d = 1'b0;
    end else if (en) begin
      if (bit_in) begin
        if (ones_q != ONES_SAT) begin
          ones_d = ones_q + 2'd1;
        end else begin
          ones_d = ones_q;
        end
      end else begin
        zpar_d = ~zpar_q;
      end
    end else begin
      ones_d = ones_q;
      zpar_d = zpar_q;
    end
    expect_nxt = (ones_d == ONES_SAT) & zpar_d;
  end

  // Model state and registered verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_q <= 2'd0;
      zpar_q <= 1'b0;
      f_q    <= 1'b0;
    end else begin
      ones_q <= ones_d;
      zpar_q <= zpar_d;
      f_q    <= expect_nxt;
    end
  end

  assign expect_f = f_q;

endmodule

// File: rtl/seq_frame_gen.sv
// Serial stimulus transmitter for the two-ones / odd-zeros recognizer.
// Accepts a frame on start, clears the recognizer for one cycle, shifts the
// frame out LSB-first and reports the model's end-of-frame verdict with done.
module seq_frame_gen #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LW-1:0]    len,
  output logic             busy,
  output logic             x,
  output logic             x_valid,
  output logic             rcv_clr,
  output logic             expect_f,
  output logic             done,
  output logic             frame_accept
);
  import seq_pkg::*;

  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [LW-1:0]    cnt_q;
  logic [LW-1:0]    cnt_d;
  logic             busy_q;
  logic             x_q;
  logic             x_valid_q;
  logic             rcv_clr_q;
  logic             done_q;
  logic             frame_accept_q;
  logic             expect_nxt_s;

  // Frame length to load: requests longer than the shift register are clamped
  always_comb begin
    if (len > WIDTH_L) begin
      cnt_d = WIDTH_L;
    end else begin
      cnt_d = len;
    end
  end

  // Handshake, clear, shift and verdict sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      sreg_q         <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      x_q            <= 1'b0;
      x_valid_q      <= 1'b0;
      rcv_clr_q      <= 1'b0;
      done_q         <= 1'b0;
      frame_accept_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sreg_q         <= data;
            cnt_q          <= cnt_d;
            busy_q         <= 1'b1;
            frame_accept_q <= 1'b0;
            if (cnt_d == '0) begin
              // empty frame: no clear, no bits, straight to the verdict
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= CLR;
              rcv_clr_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CLR: begin
          rcv_clr_q <= 1'b0;
          x_q       <= sreg_q[0];
          x_valid_q <= 1'b1;
          sreg_q    <= sreg_q >> 1;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (cnt_q == ONE_L) begin
            // last bit is being consumed at this edge; capture the model's final F
            x_q            <= 1'b0;
            x_valid_q      <= 1'b0;
            cnt_q          <= '0;
            done_q         <= 1'b1;
            frame_accept_q <= expect_nxt_s;
            state_q        <= DONE;
          end else begin
            x_q     <= sreg_q[0];
            sreg_q  <= sreg_q >> 1;
            cnt_q   <= cnt_q - ONE_L;
            state_q <= SHIFT;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          x_q       <= 1'b0;
          x_valid_q <= 1'b0;
          rcv_clr_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  seq_ref_model u_model (
    .clk        (clk),
    .rst        (rst),
    .clr        (rcv_clr_q),
    .en         (x_valid_q),
    .bit_in     (x_q),
    .expect_f   (expect_f),
    .expect_nxt (expect_nxt_s)
  );

  assign busy         = busy_q;
  assign x            = x_q;
  assign x_valid      = x_valid_q;
  assign rcv_clr      = rcv_clr_q;
  assign done         = done_q;
  assign frame_accept = frame_accept_q;

endmodule

// File: tb/tb_seq_frame_gen.sv
// Self-checking bench for seq_frame_gen: directed frames, a mid-frame reset and
// random frames with start/data/len noise while busy, checked cycle by cycle
// against a frame-level model built from counts of ones and zeros.
module tb_seq_frame_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic [3:0] len;
  logic       busy, x, x_valid, rcv_clr, expect_f, done, frame_accept;

  int checks;
  int errors;
  logic prev_f;

  seq_frame_gen #(.WIDTH(8), .LW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data         (data),
    .len          (len),
    .busy         (busy),
    .x            (x),
    .x_valid      (x_valid),
    .rcv_clr      (rcv_clr),
    .expect_f     (expect_f),
    .done         (done),
    .frame_accept (frame_accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".x"}, x, 1'b0);
    chk({tag, ".x_valid"}, x_valid, 1'b0);
    chk({tag, ".rcv_clr"}, rcv_clr, 1'b0);
    chk({tag, ".expect_f"}, expect_f, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".frame_accept"}, frame_accept, 1'b0);
  endtask

  // Send one frame starting just after a rising edge; check every cycle until idle again.
  task automatic run_frame(input logic [7:0] d, input logic [3:0] l, input bit noise);
    int   n;
    int   ones;
    int   zeros;
    int   last;
    logic fexp [0:8];
    logic e_busy, e_done, e_clr, e_xv, e_x, e_f, e_acc, final_f;
    n = (l > 4'd8) ? 8 : int'(l);
    ones = 0;
    zeros = 0;
    fexp[0] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (d[k-1]) ones++; else zeros++;
      fexp[k] = (ones >= 2) && ((zeros % 2) == 1);
    end
    final_f = (n > 0) ? fexp[n] : 1'b0;
    last = (n > 0) ? n + 3 : 2;
    start = 1'b1;
    data  = d;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (noise && c < last) begin
        start = 1'($urandom_range(0, 1));
        data  = 8'($urandom);
        len   = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      e_busy = (c < last);
      e_done = (c == last - 1);
      e_clr  = (n > 0) && (c == 1);
      e_xv   = (n > 0) && (c >= 2) && (c <= n + 1);
      e_x    = e_xv ? d[c-2] : 1'b0;
      if (n == 0 || c == 1) e_f = prev_f;
      else if (c <= n + 1)  e_f = fexp[c-2];
      else                  e_f = fexp[n];
      e_acc  = (c >= last - 1) ? final_f : 1'b0;
      @(negedge clk);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("rcv_clr", rcv_clr, e_clr);
      chk("x_valid", x_valid, e_xv);
      chk("x", x, e_x);
      chk("expect_f", expect_f, e_f);
      chk("frame_accept", frame_accept, e_acc);
      @(posedge clk); #1;
    end
    if (n > 0) prev_f = fexp[n];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_f = 1'b0;
    rst   = 1'b0;
    start = 1'b0;
    data  = 8'h00;
    len   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("post_reset_idle");

    // directed frames
    run_frame(8'b0000_0011, 4'd3, 1'b0);
    run_frame(8'b0000_0011, 4'd4, 1'b0);
    run_frame(8'h01, 4'd8, 1'b0);
    run_frame(8'hFF, 4'd15, 1'b0);
    run_frame(8'h5A, 4'd0, 1'b0);
    run_frame(8'b0000_0011, 4'd3, 1'b1);

    // len=8 frame with a second start during SHIFT, then reset at bit 2
    start = 1'b1;
    data  = 8'b1010_0110;
    len   = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;            // CLR cycle done, bit 1 now
    start = 1'b1;
    data  = 8'hFF;
    len   = 4'd2;
    @(posedge clk); #1;            // bit 2
    start = 1'b0;
    @(negedge clk);
    chk("midrst.busy", busy, 1'b1);
    chk("midrst.x_valid", x_valid, 1'b1);
    chk("midrst.x_bit2", x, 1'b1);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst.async");
    @(posedge clk); #1;
    chk_all_zero("midrst.held");
    rst = 1'b1;
    prev_f = 1'b0;
    @(posedge clk); #1;
    run_frame(8'b0000_0111, 4'd4, 1'b0);

    // random frames with noise on the inputs while busy
    for (int i = 0; i < 40; i++) begin
      run_frame(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
